// File: rtl/pic_pkg.sv
// Shared constants for the 8259-style interrupt controller blocks.
package pic_pkg;

    localparam int unsigned NUM_IR   = 8;
    localparam int unsigned IR_IDX_W = $clog2(NUM_IR);

    localparam logic LTIM_EDGE  = 1'b0;
    localparam logic LTIM_LEVEL = 1'b1;

endpackage

// File: rtl/ir_sync.sv
// Multi-flop synchroniser for the raw IR lines, plus a fill flag that marks
// when the chain output reflects real samples rather than reset contents.
module ir_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0]  sync_q [STAGES];
    logic [WIDTH-1:0]  sync_d [STAGES];
    logic [STAGES-1:0] fill_q;
    logic [STAGES-1:0] fill_d;

    always_comb begin
        sync_d[0] = d;
        for (int unsigned s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        fill_d = {fill_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            fill_q <= fill_d;
        end
    end

    assign q     = sync_q[STAGES-1];
    assign valid = fill_q[STAGES-1];

endmodule

// File: rtl/interrupt_request_unit.sv
// IRR stage of the PIC: synchronises IR lines, detects edge/level requests,
// holds them in irr (frozen during INTA) and raises int_req for unmasked bits.
module interrupt_request_unit #(
    parameter int unsigned NUM_IR      = pic_pkg::NUM_IR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_IR-1:0]             ir_in,
    input  logic                          ltim,
    input  logic                          icw1_wr,
    input  logic [NUM_IR-1:0]             imr,
    input  logic                          freeze,
    input  logic                          inta_ack,
    input  logic [pic_pkg::IR_IDX_W-1:0]  ack_id,
    output logic [NUM_IR-1:0]             irr,
    output logic                          int_req
);

    import pic_pkg::*;

    logic [NUM_IR-1:0] ir_s;
    logic              sync_vld;

    logic [NUM_IR-1:0] prev_q, prev_d;
    logic [NUM_IR-1:0] pend_q, pend_d;
    logic [NUM_IR-1:0] irr_q,  irr_d;
    logic              int_req_q, int_req_d;

    logic [NUM_IR-1:0] edge_det;
    logic [NUM_IR-1:0] ack_clr;

    ir_sync #(
        .WIDTH  (NUM_IR),
        .STAGES (SYNC_STAGES)
    ) u_ir_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ir_in),
        .q     (ir_s),
        .valid (sync_vld)
    );

    always_comb begin
        ack_clr = '0;
        for (int unsigned i = 0; i < NUM_IR; i++) begin
            ack_clr[i] = inta_ack && (ack_id == IR_IDX_W'(i));
        end

        edge_det  = ir_s & ~prev_q;
        // Reset contents of the chain are not a real low: keep edge sense disarmed.
        prev_d    = sync_vld ? ir_s : '1;
        irr_d     = irr_q;
        pend_d    = pend_q;
        int_req_d = |(irr_q & ~imr);

        if (icw1_wr) begin
            irr_d     = '0;
            pend_d    = '0;
            int_req_d = 1'b0;
            prev_d    = '1;
        end else if (ltim == LTIM_LEVEL) begin
            pend_d = '0;
            irr_d  = (freeze ? irr_q : ir_s) & ~ack_clr;
        end else if (freeze) begin
            pend_d = pend_q | edge_det;
            irr_d  = irr_q & ~ack_clr;
        end else begin
            // An edge colliding with its own ack is parked in pend for one cycle.
            irr_d  = (irr_q | edge_det | pend_q) & ~ack_clr;
            pend_d = (pend_q | edge_det) & ack_clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '1;
            pend_q    <= '0;
            irr_q     <= '0;
            int_req_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            irr_q     <= irr_d;
            int_req_q <= int_req_d;
        end
    end

    assign irr     = irr_q;
    assign int_req = int_req_q;

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Bench for interrupt_request_unit: directed vector table, reset sequences,
// and randomized traffic against a per-bit behavioural model.
module tb_interrupt_request_unit;

    import pic_pkg::*;

    localparam int unsigned NIR  = 8;
    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir_in;
    logic       ltim;
    logic       icw1_wr;
    logic [7:0] imr;
    logic       freeze;
    logic       inta_ack;
    logic [2:0] ack_id;
    logic [7:0] irr;
    logic       int_req;

    int checks   = 0;
    int failures = 0;

    interrupt_request_unit #(
        .NUM_IR      (NIR),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir_in    (ir_in),
        .ltim     (ltim),
        .icw1_wr  (icw1_wr),
        .imr      (imr),
        .freeze   (freeze),
        .inta_ack (inta_ack),
        .ack_id   (ack_id),
        .irr      (irr),
        .int_req  (int_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ir;
        logic       lt;
        logic       ic;
        logic [7:0] mk;
        logic       fz;
        logic       ak;
        logic [2:0] id;
        logic [7:0] e_irr;
        logic       e_int;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    logic [7:0] m_irr, m_pend, m_low;
    logic       m_int;
    logic [7:0] m_samp[$];

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %02h expected %02h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic v(input logic [7:0] ir, input logic lt, input logic ic, input logic [7:0] mk,
                     input logic fz, input logic ak, input logic [2:0] id,
                     input logic [7:0] e_irr, input logic e_int);
        vec_t r;
        r = '{ir, lt, ic, mk, fz, ak, id, e_irr, e_int};
        tbl.push_back(r);
    endtask

    task automatic model_reset();
        m_irr  = '0;
        m_pend = '0;
        m_low  = '0;
        m_int  = 1'b0;
        m_samp.delete();
    endtask

    // One clock of the model, using the inputs currently driven.
    task automatic model_step();
        logic [7:0] s, n_irr, n_pend;
        logic       vld, hit, e, n_int;
        vld    = (m_samp.size() == SYNC);
        s      = vld ? m_samp[0] : 8'h00;
        n_int  = icw1_wr ? 1'b0 : |(m_irr & ~imr);
        n_irr  = m_irr;
        n_pend = m_pend;
        for (int i = 0; i < 8; i++) begin
            hit = inta_ack && (int'(ack_id) == i);
            e   = vld && s[i] && m_low[i];
            if (icw1_wr) begin
                n_irr[i]  = 1'b0;
                n_pend[i] = 1'b0;
            end else if (ltim) begin
                n_pend[i] = 1'b0;
                if (hit)         n_irr[i] = 1'b0;
                else if (!freeze) n_irr[i] = s[i];
            end else if (freeze) begin
                n_pend[i] = m_pend[i] | e;
                if (hit) n_irr[i] = 1'b0;
            end else if (hit) begin
                n_irr[i]  = 1'b0;
                n_pend[i] = m_pend[i] | e;
            end else begin
                n_irr[i]  = m_irr[i] | e | m_pend[i];
                n_pend[i] = 1'b0;
            end
        end
        if (icw1_wr)  m_low = '0;
        else if (vld) m_low = ~s;
        m_irr  = n_irr;
        m_pend = n_pend;
        m_int  = n_int;
        m_samp.push_back(ir_in);
        if (m_samp.size() > SYNC) void'(m_samp.pop_front());
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ir_in    = 8'hFF;
        ltim     = LTIM_EDGE;
        icw1_wr  = 1'b0;
        imr      = 8'h00;
        freeze   = 1'b0;
        inta_ack = 1'b0;
        ack_id   = 3'd0;

        // Reset with lines high, then hold them high: no request may appear.
        repeat (3) tick();
        chk8("reset_irr", irr, 8'h00);
        chk1("reset_int", int_req, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk8("hold_high_irr", irr, 8'h00);
        end
        chk1("hold_high_int", int_req, 1'b0);
        ir_in = 8'h00;
        repeat (4) tick();
        chk8("idle_irr", irr, 8'h00);

        //   ir     lt    ic    imr    fz    ak    id     irr    int
        v(8'h24, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h24, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h24, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24, 1'b0);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24, 1'b1);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24, 1'b1);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24, 1'b1);
        v(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h24, 1'b0, 1'b0, 8'h24, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h24, 1'b0, 1'b0, 8'h24, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h24, 1'b0, 1'b0, 8'h24, 1'b0, 1'b0, 3'd0, 8'h24, 1'b0);
        v(8'h24, 1'b0, 1'b0, 8'h24, 1'b0, 1'b0, 3'd0, 8'h24, 1'b0);
        v(8'h24, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 3'd0, 8'h24, 1'b1);
        v(8'h25, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h24, 1'b1);
        v(8'h25, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h24, 1'b1);
        v(8'h25, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'h04, 1'b1);
        v(8'h25, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h04, 1'b1);
        v(8'h25, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h05, 1'b1);
        v(8'h2D, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h05, 1'b1);
        v(8'h2D, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h05, 1'b1);
        v(8'h2D, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h05, 1'b1);
        v(8'h2D, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h0D, 1'b1);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h0D, 1'b1);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h0D, 1'b1);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h0D, 1'b1);
        v(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h0D, 1'b1);
        v(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h0D, 1'b1);
        v(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b1);
        v(8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0);
        v(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1);
        v(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1);
        v(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        v(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'h00, 1'b1);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0);
        v(8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1);
        v(8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1);

        foreach (tbl[k]) begin
            ir_in    = tbl[k].ir;
            ltim     = tbl[k].lt;
            icw1_wr  = tbl[k].ic;
            imr      = tbl[k].mk;
            freeze   = tbl[k].fz;
            inta_ack = tbl[k].ak;
            ack_id   = tbl[k].id;
            tick();
            chk8($sformatf("vec%0d_irr", k), irr, tbl[k].e_irr);
            chk1($sformatf("vec%0d_int", k), int_req, tbl[k].e_int);
        end
        icw1_wr  = 1'b0;
        inta_ack = 1'b0;

        // Asynchronous reset in the middle of activity clears state at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_rst_irr", irr, 8'h00);
        chk1("async_rst_int", int_req, 1'b0);
        ir_in  = 8'h00;
        ltim   = LTIM_EDGE;
        imr    = 8'h00;
        freeze = 1'b0;
        repeat (3) tick();
        model_reset();
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            int b;
            b = int'($urandom_range(7));
            if ($urandom_range(3) == 0) ir_in[b] = ~ir_in[b];
            if ($urandom_range(63) == 0) ltim = ~ltim;
            if ($urandom_range(7) == 0) freeze = ~freeze;
            if ($urandom_range(15) == 0) imr = 8'($urandom);
            icw1_wr  = ($urandom_range(49) == 0);
            inta_ack = ($urandom_range(5) == 0);
            ack_id   = 3'($urandom_range(7));
            model_step();
            tick();
            chk8("rand_irr", irr, m_irr);
            chk1("rand_int", int_req, m_int);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
